// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the sampled-TCK JTAG TAP:
//   tap_state_e  - 16 TAP states, 4-bit encoding (exported on tap_state_o)
//   IR_WIDTH     - default instruction register width
//   IDCODE_IR    - IDCODE opcode, also the IR reset value
//   BYPASS_IR    - BYPASS opcode
//   JTAG_IDCODE  - default IDCODE value (bit0 = 1)
//   tap_next()   - 1149.1 next-state function, TMS sampled on TCK rise
// ---------------------------------------------------------------------------
package jtag_pkg;

   localparam int unsigned IR_WIDTH    = 5;
   localparam logic [4:0]  IDCODE_IR   = 5'h01;
   localparam logic [4:0]  BYPASS_IR   = 5'h1F;
   localparam logic [31:0] JTAG_IDCODE = 32'h04F5484D;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   return tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          return TEST_LOGIC_RESET;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// TAP state register; advances one step per enabled cycle (one TCK rise).
//   i_clk   - system clock
//   i_rst   - synchronous reset, active-high (forces TEST_LOGIC_RESET)
//   i_en    - TCK rise detected this cycle
//   i_tms   - TMS value belonging to that rise
//   o_state - current TAP state
//   o_next  - state that will be taken on the current rise
// ---------------------------------------------------------------------------
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_tms,
   output tap_state_e o_state,
   output tap_state_e o_next
);

   tap_state_e r_state;

   assign o_state = r_state;
   assign o_next  = tap_next(r_state, i_tms);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= TEST_LOGIC_RESET;
      end else if (i_en) begin
         r_state <= tap_next(r_state, i_tms);
      end
   end

endmodule

// File: rtl/jtag_tap_sampled.sv
// ---------------------------------------------------------------------------
// jtag_tap_sampled
// IEEE 1149.1 TAP controller with TCK oversampled on the system clock.
// Holds IR, IDCODE and BYPASS; other data registers live outside and attach
// through the dr_* capture/shift/update strobes when dr_sel_i is set.
// Optional macro JTAG_TAP_SYNC_EN: adds 2-flop synchronisers on
// TCK/TMS/TDI/TRST (pin-to-effect latency 3 clocks instead of 1).
// Ports:
//   clock         - system clock, only clock
//   reset_i       - synchronous reset, active-high
//   jtag_tck_i    - TCK, sampled as data
//   jtag_tms_i    - TMS
//   jtag_tdi_i    - TDI
//   jtag_trst_ni  - TRST, active-low, sampled
//   jtag_tdo_o    - TDO, updated on TCK fall
//   ir_o          - current instruction
//   tap_state_o   - TAP state (jtag_pkg::tap_state_e encoding)
//   dr_capture_o  - pulse: Capture-DR with external DR selected
//   dr_shift_o    - pulse per TCK rise in Shift-DR with external DR selected
//   dr_update_o   - pulse: Update-DR with external DR selected
//   dr_tdi_o      - TDI bit valid with dr_shift_o
//   dr_tdo_i      - LSB of external DR
//   dr_sel_i      - current IR selects an external DR
// ---------------------------------------------------------------------------
module jtag_tap_sampled
   import jtag_pkg::*;
#(
   parameter int unsigned          IrWidth  = IR_WIDTH,
   parameter logic [31:0]          JtagId   = JTAG_IDCODE,
   parameter logic [IrWidth-1:0]   IdcodeIr = IrWidth'(IDCODE_IR),
   parameter logic [IrWidth-1:0]   BypassIr = IrWidth'(BYPASS_IR)
) (
   input  logic               clock,
   input  logic               reset_i,
   input  logic               jtag_tck_i,
   input  logic               jtag_tms_i,
   input  logic               jtag_tdi_i,
   input  logic               jtag_trst_ni,
   output logic               jtag_tdo_o,
   output logic [IrWidth-1:0] ir_o,
   output logic [3:0]         tap_state_o,
   output logic               dr_capture_o,
   output logic               dr_shift_o,
   output logic               dr_update_o,
   output logic               dr_tdi_o,
   input  logic               dr_tdo_i,
   input  logic               dr_sel_i
);

   logic w_tck;
   logic w_tms;
   logic w_tdi;
   logic w_trst_n;

`ifdef JTAG_TAP_SYNC_EN
   logic [1:0] r_tck_sync;
   logic [1:0] r_tms_sync;
   logic [1:0] r_tdi_sync;
   logic [1:0] r_trst_sync;

   // Synchronisers are cleared by reset_i only; TRST itself travels through them.
   always_ff @(posedge clock) begin
      if (reset_i) begin
         r_tck_sync  <= '0;
         r_tms_sync  <= '1;
         r_tdi_sync  <= '0;
         r_trst_sync <= '1;
      end else begin
         r_tck_sync  <= {r_tck_sync[0],  jtag_tck_i};
         r_tms_sync  <= {r_tms_sync[0],  jtag_tms_i};
         r_tdi_sync  <= {r_tdi_sync[0],  jtag_tdi_i};
         r_trst_sync <= {r_trst_sync[0], jtag_trst_ni};
      end
   end

   assign w_tck    = r_tck_sync[1];
   assign w_tms    = r_tms_sync[1];
   assign w_tdi    = r_tdi_sync[1];
   assign w_trst_n = r_trst_sync[1];
`else
   assign w_tck    = jtag_tck_i;
   assign w_tms    = jtag_tms_i;
   assign w_tdi    = jtag_tdi_i;
   assign w_trst_n = jtag_trst_ni;
`endif

   logic               r_tck_q;
   logic               w_rst;
   logic               w_rise;
   logic               w_fall;
   tap_state_e         w_state;
   tap_state_e         w_next;
   logic               w_dr_idcode;

   logic [IrWidth-1:0] r_ir;
   logic [IrWidth-1:0] r_ir_sr;
   logic [31:0]        r_idcode;
   logic               r_bypass;
   logic               r_tdo;
   logic               r_dr_capture;
   logic               r_dr_shift;
   logic               r_dr_update;
   logic               r_dr_tdi;

   assign w_rst  = reset_i | ~w_trst_n;
   assign w_rise = w_tck & ~r_tck_q;
   assign w_fall = ~w_tck & r_tck_q;

   // Anything not IDCODE and not claimed externally falls back to BYPASS.
   assign w_dr_idcode = ~dr_sel_i & (r_ir == IdcodeIr) & (IdcodeIr != BypassIr);

   jtag_tap_fsm u_fsm (
      .i_clk   (clock),
      .i_rst   (w_rst),
      .i_en    (w_rise),
      .i_tms   (w_tms),
      .o_state (w_state),
      .o_next  (w_next)
   );

   always_ff @(posedge clock) begin
      if (w_rst) begin
         r_tck_q      <= 1'b0;
         r_ir         <= IdcodeIr;
         r_ir_sr      <= '0;
         r_idcode     <= '0;
         r_bypass     <= 1'b0;
         r_tdo        <= 1'b0;
         r_dr_capture <= 1'b0;
         r_dr_shift   <= 1'b0;
         r_dr_update  <= 1'b0;
         r_dr_tdi     <= 1'b0;
      end else begin
         r_tck_q      <= w_tck;
         r_dr_capture <= 1'b0;
         r_dr_shift   <= 1'b0;
         r_dr_update  <= 1'b0;

         // Rise: act on the state being left, then the FSM steps in parallel.
         if (w_rise) begin
            case (w_state)
               CAPTURE_IR: r_ir_sr <= IrWidth'(2'b01);
               SHIFT_IR:   r_ir_sr <= {w_tdi, r_ir_sr[IrWidth-1:1]};
               CAPTURE_DR: begin
                  if (dr_sel_i)         r_dr_capture <= 1'b1;
                  else if (w_dr_idcode) r_idcode     <= JtagId;
                  else                  r_bypass     <= 1'b0;
               end
               SHIFT_DR: begin
                  if (dr_sel_i) begin
                     r_dr_shift <= 1'b1;
                     r_dr_tdi   <= w_tdi;
                  end else if (w_dr_idcode) begin
                     r_idcode <= {w_tdi, r_idcode[31:1]};
                  end else begin
                     r_bypass <= w_tdi;
                  end
               end
               UPDATE_DR: begin
                  if (dr_sel_i) r_dr_update <= 1'b1;
               end
               default: ;
            endcase
            if (w_next == TEST_LOGIC_RESET) r_ir <= IdcodeIr;
         end

         // Fall: drive TDO from the active shift path and commit a new IR.
         if (w_fall) begin
            case (w_state)
               SHIFT_IR: r_tdo <= r_ir_sr[0];
               SHIFT_DR: begin
                  if (dr_sel_i)         r_tdo <= dr_tdo_i;
                  else if (w_dr_idcode) r_tdo <= r_idcode[0];
                  else                  r_tdo <= r_bypass;
               end
               default:  r_tdo <= 1'b0;
            endcase
            if (w_state == UPDATE_IR) r_ir <= r_ir_sr;
         end
      end
   end

   assign jtag_tdo_o   = r_tdo;
   assign ir_o         = r_ir;
   assign tap_state_o  = w_state;
   assign dr_capture_o = r_dr_capture;
   assign dr_shift_o   = r_dr_shift;
   assign dr_update_o  = r_dr_update;
   assign dr_tdi_o     = r_dr_tdi;

endmodule
